au_acc_sched: RTL and testbench
===============================

Name: au_acc_sched

Overview:
- Sequencing controller for one Aunit.
- Accepts a layer configuration and drives the Aunit control fields: work enable, mode, number types and lane mask.
- Consumes the Aunit partial-sum stream and accumulates AccLen partial sums per output pixel into a wide signed accumulator.
- Emits OutNum accumulated results downstream, then returns to idle. Sits between the PE control sequencer and the PE output buffer.

Parameters:
- SumWd, 16, width of the Aunit partial sum (matches AuODWd)
- AccWd, 24, accumulator/output width
- MaskWd, 64, Aunit lane-mask width
- CntWd, 12, width of the AccLen/OutNum counters

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_cfg_rdy  in  1  config valid
- o_cfg_ack  out  1  config accepted
- i_cfg_mode  in  2  0=XNOR, 1=M1, 2=M2, 3=M4
- i_cfg_inumt  in  1  ipix number type, 1=SIGNED
- i_cfg_wnumt  in  1  wpix number type, 1=SIGNED
- i_cfg_acclen  in  CntWd  partial sums per output, value minus 1
- i_cfg_outnum  in  CntWd  outputs per layer, value minus 1
- i_cfg_tailmask  in  MaskWd  lane mask for the last partial sum of each output
- o_cont_work  out  1  Aunit work enable
- o_cont_mode  out  2  Aunit mode
- o_cont_inumt  out  1  Aunit ipix number type
- o_cont_wnumt  out  1  Aunit wpix number type
- o_cont_mask  out  MaskWd  Aunit lane mask
- i_sum  in  SumWd  Aunit sum, signed
- i_sum_rdy  in  1  sum valid
- i_sum_zero  in  1  sum zero flag; zero sums are accumulated as 0
- o_sum_ack  out  1  sum accepted
- o_acc  out  AccWd  accumulated result, signed
- o_acc_rdy  out  1  result valid
- i_acc_ack  in  1  result accepted
- o_busy  out  1  layer in progress
- o_done  out  1  one-cycle pulse after the last result transfers

Behaviour:
- Reset (async, i_rstn low), all registered outputs cleared:
  - o_cfg_ack, o_cont_work, o_sum_ack, o_acc_rdy, o_busy, o_done = 0
  - o_cont_mode = 0, o_cont_inumt = 0, o_cont_wnumt = 0, o_acc = 0
  - o_cont_mask = all ones
  - counters cleared; FSM = IDLE
- Reset asserted mid-layer abandons the layer and discards any pending result.
- Transfers: a transfer occurs on a cycle where rdy && ack, for all three handshakes.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - o_cfg_ack = 1 combinationally.
  - On cfg transfer: latch all cfg fields, clear acc and both counters, go to RUN.
- RUN:
  - o_cont_work = 1, o_busy = 1.
  - o_sum_ack = !o_acc_rdy || i_acc_ack. This makes RUN a one-stage skid: a new sum is accepted in the same cycle as the prior result leaves.
  - On sum transfer: acc_next = (pc==0 ? 0 : acc) + sign_extend(i_zero ? 0 : i_sum). Result saturates to [-2^(AccWd-1), 2^(AccWd-1)-1].
  - Partial counter pc increments; when pc == acclen, the sum just taken is the last partial for this output:
    - o_acc <= acc_next, o_acc_rdy <= 1, pc <= 0, oc increments.
  - If that transfer has oc == outnum, go to FLUSH.
- Mask:
  - o_cont_mask = tailmask when the next sum to be accepted is the last partial (pc == acclen); otherwise all ones.
  - Registered, so it updates in the cycle after the preceding sum transfer.
  - With acclen == 0, tailmask applies to every sum.
- FLUSH:
  - o_cont_work = 0, o_sum_ack = 0.
  - Wait for the final result transfer, then go to DONE.
- DONE:
  - o_done = 1 for one cycle, o_busy = 0.
  - Go to IDLE.
- o_acc_rdy holds with o_acc stable until i_acc_ack; back-to-back results with i_acc_ack held high sustain one result per AccLen sums.
- Config fields are ignored outside IDLE; i_cfg_rdy in any other state gets no ack.
- o_cont_mode, o_cont_inumt and o_cont_wnumt hold the latched config from the cycle after the cfg transfer until the next cfg transfer.
- Counter wrap: acclen and outnum at the all-ones maximum must work, i.e. 2^CntWd items, with no overflow of pc/oc.
- Latency: the result appears on o_acc_rdy the cycle after the last partial-sum transfer.

Test Plan:
- Basic accumulation: mode=M4, acclen=3, outnum=1; sums 10,-3,5,7 then 1,1,1,1 with acc_ack held 1 -> results 19 then 4, o_done pulse, o_busy low, back to IDLE.
- Tail mask: acclen=2, tailmask=0x00FF -> o_cont_mask = all-ones, all-ones, 0x00FF across the three sums of each output; repeats per output.
- Backpressure: acc_ack=0 for 5 cycles while a result is pending -> o_sum_ack=0, o_acc stable; on ack, the next sum is accepted the same cycle.
- Saturation with AccWd=24: acclen=0xFFF, every sum = 0x7FFF -> o_acc = 0x7FFFFF. Same with 0x8000 -> 0x800000.
- Zero flag: i_sum=0x1234 with i_sum_zero=1 -> contributes 0; acclen=0 gives o_acc=0.
- Async reset mid-RUN: after 2 of 4 sums, pull i_rstn low -> outputs at reset values immediately; a new cfg after release runs cleanly with no residue from the previous acc.

Source files
------------

// File: rtl/au_acc_sched_if.sv
// Bundle of the config, Aunit control, partial-sum and result signals of au_acc_sched.
// Handshake rule: on all three channels (cfg, sum, acc), a transfer happens on any
// rising clock edge where the producer's *_rdy and the consumer's *_ack are both high.
// The producer holds its payload stable while rdy is high and ack is low.
// The master modport is the environment side. The slave modport is the scheduler side.
interface au_acc_sched_if #(
  parameter int SumWd  = 16,
  parameter int AccWd  = 24,
  parameter int MaskWd = 64,
  parameter int CntWd  = 12
);
  logic              i_cfg_rdy;
  logic              o_cfg_ack;
  logic [1:0]        i_cfg_mode;
  logic              i_cfg_inumt;
  logic              i_cfg_wnumt;
  logic [CntWd-1:0]  i_cfg_acclen;
  logic [CntWd-1:0]  i_cfg_outnum;
  logic [MaskWd-1:0] i_cfg_tailmask;
  logic              o_cont_work;
  logic [1:0]        o_cont_mode;
  logic              o_cont_inumt;
  logic              o_cont_wnumt;
  logic [MaskWd-1:0] o_cont_mask;
  logic [SumWd-1:0]  i_sum;
  logic              i_sum_rdy;
  logic              i_sum_zero;
  logic              o_sum_ack;
  logic [AccWd-1:0]  o_acc;
  logic              o_acc_rdy;
  logic              i_acc_ack;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_dbg_state;

  modport master (
    output i_cfg_rdy, i_cfg_mode, i_cfg_inumt, i_cfg_wnumt, i_cfg_acclen, i_cfg_outnum,
           i_cfg_tailmask, i_sum, i_sum_rdy, i_sum_zero, i_acc_ack,
    input  o_cfg_ack, o_cont_work, o_cont_mode, o_cont_inumt, o_cont_wnumt, o_cont_mask,
           o_sum_ack, o_acc, o_acc_rdy, o_busy, o_done, o_dbg_state
  );

  modport slave (
    input  i_cfg_rdy, i_cfg_mode, i_cfg_inumt, i_cfg_wnumt, i_cfg_acclen, i_cfg_outnum,
           i_cfg_tailmask, i_sum, i_sum_rdy, i_sum_zero, i_acc_ack,
    output o_cfg_ack, o_cont_work, o_cont_mode, o_cont_inumt, o_cont_wnumt, o_cont_mask,
           o_sum_ack, o_acc, o_acc_rdy, o_busy, o_done, o_dbg_state
  );
endinterface

// File: rtl/au_acc_sched.sv
// Aunit sequencing controller: takes a layer config and drives the Aunit controls.
// It accumulates AccLen partial sums per output pixel with saturation.
// It emits OutNum results, then pulses done and returns to idle.
module au_acc_sched #(
  parameter int SumWd  = 16,
  parameter int AccWd  = 24,
  parameter int MaskWd = 64,
  parameter int CntWd  = 12
) (
  input logic         i_clk,
  input logic         i_rstn,
  au_acc_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic signed [AccWd:0] AccMax = {2'b00, {(AccWd-1){1'b1}}};
  localparam logic signed [AccWd:0] AccMin = {2'b11, {(AccWd-1){1'b0}}};
  localparam logic [MaskWd-1:0]     MaskOnes = {MaskWd{1'b1}};

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              inumt_q, inumt_d, wnumt_q, wnumt_d;
  logic [CntWd-1:0]  acclen_q, acclen_d, outnum_q, outnum_d;
  logic [MaskWd-1:0] tail_q, tail_d, mask_q, mask_d;
  logic [CntWd-1:0]  pc_q, pc_d, oc_q, oc_d;
  logic [AccWd-1:0]  acc_q, acc_d, out_q, out_d;
  logic              acc_rdy_q, acc_rdy_d;
  logic              work_q, work_d, busy_q, busy_d, done_q, done_d;

  logic                    cfg_ack, sum_ack, cfg_xfer, sum_xfer, acc_xfer;
  logic [CntWd-1:0]        pc_inc;
  logic signed [AccWd:0]   acc_base, sum_ext, acc_wide;
  logic [AccWd-1:0]        acc_sat;

  // Config is only taken in idle. Reset also forces the ack low.
  // The sum ack lets a new sum in on the same cycle the held result leaves.
  assign cfg_ack  = (state_q == S_IDLE) && i_rstn;
  assign sum_ack  = (state_q == S_RUN) && (!acc_rdy_q || bus.i_acc_ack);
  assign cfg_xfer = cfg_ack && bus.i_cfg_rdy;
  assign sum_xfer = sum_ack && bus.i_sum_rdy;
  assign acc_xfer = acc_rdy_q && bus.i_acc_ack;
  assign pc_inc   = pc_q + CntWd'(1);

  // Saturating accumulate: one extra bit of headroom, then clamp to the AccWd range.
  always_comb begin
    acc_base = (pc_q == '0) ? '0 : {acc_q[AccWd-1], acc_q};
    sum_ext  = bus.i_sum_zero ? '0 : {{(AccWd+1-SumWd){bus.i_sum[SumWd-1]}}, bus.i_sum};
    acc_wide = acc_base + sum_ext;
    if (acc_wide > AccMax)      acc_sat = AccMax[AccWd-1:0];
    else if (acc_wide < AccMin) acc_sat = AccMin[AccWd-1:0];
    else                        acc_sat = acc_wide[AccWd-1:0];
  end

  // Next-state logic: layer FSM, counters, mask look-ahead and the result holding register.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    inumt_d   = inumt_q;
    wnumt_d   = wnumt_q;
    acclen_d  = acclen_q;
    outnum_d  = outnum_q;
    tail_d    = tail_q;
    mask_d    = mask_q;
    pc_d      = pc_q;
    oc_d      = oc_q;
    acc_d     = acc_q;
    out_d     = out_q;
    acc_rdy_d = acc_rdy_q && !bus.i_acc_ack;
    case (state_q)
      S_IDLE: begin
        if (cfg_xfer) begin
          mode_d   = bus.i_cfg_mode;
          inumt_d  = bus.i_cfg_inumt;
          wnumt_d  = bus.i_cfg_wnumt;
          acclen_d = bus.i_cfg_acclen;
          outnum_d = bus.i_cfg_outnum;
          tail_d   = bus.i_cfg_tailmask;
          pc_d     = '0;
          oc_d     = '0;
          acc_d    = '0;
          mask_d   = (bus.i_cfg_acclen == '0) ? bus.i_cfg_tailmask : MaskOnes;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (sum_xfer) begin
          acc_d = acc_sat;
          if (pc_q == acclen_q) begin
            out_d     = acc_sat;
            acc_rdy_d = 1'b1;
            pc_d      = '0;
            oc_d      = oc_q + CntWd'(1);
            mask_d    = (acclen_q == '0) ? tail_q : MaskOnes;
            if (oc_q == outnum_q) begin
              mask_d  = MaskOnes;
              state_d = S_FLUSH;
            end
          end else begin
            pc_d   = pc_inc;
            mask_d = (pc_inc == acclen_q) ? tail_q : MaskOnes;
          end
        end
      end
      S_FLUSH: begin
        if (acc_xfer) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    work_d = (state_d == S_RUN);
    busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; async reset abandons any layer in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      inumt_q   <= 1'b0;
      wnumt_q   <= 1'b0;
      acclen_q  <= '0;
      outnum_q  <= '0;
      tail_q    <= MaskOnes;
      mask_q    <= MaskOnes;
      pc_q      <= '0;
      oc_q      <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      acc_rdy_q <= 1'b0;
      work_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      inumt_q   <= inumt_d;
      wnumt_q   <= wnumt_d;
      acclen_q  <= acclen_d;
      outnum_q  <= outnum_d;
      tail_q    <= tail_d;
      mask_q    <= mask_d;
      pc_q      <= pc_d;
      oc_q      <= oc_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      acc_rdy_q <= acc_rdy_d;
      work_q    <= work_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_cfg_ack    = cfg_ack;
  assign bus.o_sum_ack    = sum_ack;
  assign bus.o_cont_work  = work_q;
  assign bus.o_cont_mode  = mode_q;
  assign bus.o_cont_inumt = inumt_q;
  assign bus.o_cont_wnumt = wnumt_q;
  assign bus.o_cont_mask  = mask_q;
  assign bus.o_acc        = out_q;
  assign bus.o_acc_rdy    = acc_rdy_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_dbg_state  = state_q;
endmodule

// File: tb/tb_au_acc_sched.sv
// Bench for au_acc_sched: layers of partial sums are checked against a saturating
// integer accumulation model. Expected results are queued, and a negedge monitor
// compares them as results appear.
module tb_au_acc_sched;
  localparam int SumWd = 16, AccWd = 24, MaskWd = 64, CntWd = 12;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  au_acc_sched_if #(.SumWd(SumWd), .AccWd(AccWd), .MaskWd(MaskWd), .CntWd(CntWd)) bus();
  au_acc_sched #(.SumWd(SumWd), .AccWd(AccWd), .MaskWd(MaskWd), .CntWd(CntWd)) dut (
    .i_clk(clk), .i_rstn(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [AccWd-1:0] exp_q[$];
  logic [15:0] sum_v[$];
  bit          zero_v[$];
  int   ack_mode = 0;   // 0: always ack, 1: random ack, 2: never ack
  bit   mon_en = 0;
  logic [1:0] cur_mode;
  logic cur_inumt, cur_wnumt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per output, a plain integer sum clamped after every step.
  task automatic model(input int acclen, input int outnum);
    int idx = 0;
    for (int o = 0; o <= outnum; o++) begin
      longint acc = 0;
      for (int p = 0; p <= acclen; p++) begin
        acc += zero_v[idx] ? 64'sd0 : longint'($signed(sum_v[idx]));
        if (acc > 8388607) acc = 8388607;
        if (acc < -8388608) acc = -8388608;
        idx++;
      end
      exp_q.push_back(AccWd'(acc));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cfg_ack"}, 64'(bus.o_cfg_ack), 64'd0);
    check({tag, "_work"},    64'(bus.o_cont_work), 64'd0);
    check({tag, "_sum_ack"}, 64'(bus.o_sum_ack), 64'd0);
    check({tag, "_acc_rdy"}, 64'(bus.o_acc_rdy), 64'd0);
    check({tag, "_busy"},    64'(bus.o_busy), 64'd0);
    check({tag, "_done"},    64'(bus.o_done), 64'd0);
    check({tag, "_mode"},    64'({bus.o_cont_mode, bus.o_cont_inumt, bus.o_cont_wnumt}), 64'd0);
    check({tag, "_acc"},     64'(bus.o_acc), 64'd0);
    check({tag, "_mask"},    bus.o_cont_mask, Ones);
  endtask

  // Result-ack driver
  initial begin
    bus.i_acc_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: bus.i_acc_ack = 1'b1;
        1: bus.i_acc_ack = 1'($urandom_range(0, 1));
        default: bus.i_acc_ack = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.o_acc_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL acc_unexpected actual=%0h expected=none", bus.o_acc);
        end else begin
          check("acc_value", 64'(bus.o_acc), 64'(exp_q[0]));
          if (bus.i_acc_ack) void'(exp_q.pop_front());
        end
      end
      if (bus.o_cont_work)
        check("sum_ack_rule", 64'(bus.o_sum_ack), 64'(!bus.o_acc_rdy || bus.i_acc_ack));
      if (bus.o_busy) begin
        check("cfg_ack_busy", 64'(bus.o_cfg_ack), 64'd0);
        check("cont_cfg", 64'({bus.o_cont_mode, bus.o_cont_inumt, bus.o_cont_wnumt}),
              64'({cur_mode, cur_inumt, cur_wnumt}));
      end
    end
  end

  // Layer driver. kind: 0 random, 1 all 0x7FFF, 2 all 0x8000, 3 preloaded sum_v/zero_v.
  // abort_at >= 0 pulls reset just before that sum is offered.
  task automatic run_layer(input logic [1:0] mode, input int acclen, input int outnum,
                           input logic [63:0] tail, input int kind, input bit gaps,
                           input int abort_at);
    int total = (acclen + 1) * (outnum + 1);
    int n;
    bit seen, tmo;
    if (kind != 3) begin
      sum_v.delete(); zero_v.delete();
      for (int i = 0; i < total; i++) begin
        case (kind)
          1: begin sum_v.push_back(16'h7FFF); zero_v.push_back(1'b0); end
          2: begin sum_v.push_back(16'h8000); zero_v.push_back(1'b0); end
          default: begin
            sum_v.push_back(16'($urandom_range(0, 65535)));
            zero_v.push_back($urandom_range(0, 7) == 0);
          end
        endcase
      end
    end
    model(acclen, outnum);
    cur_mode = mode; cur_inumt = 1'($urandom_range(0, 1)); cur_wnumt = 1'($urandom_range(0, 1));
    bus.i_cfg_rdy = 1'b1; bus.i_cfg_mode = mode; bus.i_cfg_inumt = cur_inumt;
    bus.i_cfg_wnumt = cur_wnumt; bus.i_cfg_acclen = CntWd'(acclen);
    bus.i_cfg_outnum = CntWd'(outnum); bus.i_cfg_tailmask = tail;
    seen = 0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.o_cfg_ack) begin seen = 1; break; end
    end
    check("cfg_accepted", 64'(seen), 64'd1);
    if (!seen) begin bus.i_cfg_rdy = 1'b0; return; end
    @(posedge clk); #1;
    // Junk config offered while busy must be ignored.
    bus.i_cfg_mode = ~mode; bus.i_cfg_inumt = ~cur_inumt; bus.i_cfg_wnumt = ~cur_wnumt;
    bus.i_cfg_acclen = '0; bus.i_cfg_outnum = '0;
    tmo = 0;
    for (int k = 0; k < total; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        bus.i_sum_rdy = 1'b0; bus.i_cfg_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.i_sum_rdy = 1'b0;
        @(posedge clk); #1;
      end
      bus.i_sum_rdy = 1'b1; bus.i_sum = sum_v[k]; bus.i_sum_zero = zero_v[k];
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.o_sum_ack) begin
          check("tail_mask", bus.o_cont_mask, ((k % (acclen + 1)) == acclen) ? tail : Ones);
          @(posedge clk); #1;
          break;
        end
        n++;
        if (n > 200) begin
          checks++; errors++; tmo = 1;
          $display("FAIL sum_timeout actual=no_ack expected=ack sum=%0d", k);
          break;
        end
      end
      if (tmo) break;
    end
    bus.i_sum_rdy = 1'b0; bus.i_cfg_rdy = 1'b0;
    seen = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.o_done) begin seen = 1; break; end
    end
    check("done_pulse", 64'(seen), 64'd1);
    check("busy_at_done", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.o_done), 64'd0);
    check("idle_cfg_ack", 64'(bus.o_cfg_ack), 64'd1);
    check("results_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.i_cfg_rdy = 0; bus.i_cfg_mode = 0; bus.i_cfg_inumt = 0; bus.i_cfg_wnumt = 0;
    bus.i_cfg_acclen = 0; bus.i_cfg_outnum = 0; bus.i_cfg_tailmask = 0;
    bus.i_sum = 0; bus.i_sum_rdy = 0; bus.i_sum_zero = 0;
    cur_mode = 0; cur_inumt = 0; cur_wnumt = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1;

    // Basic: 10-3+5+7 = 19, then 1+1+1+1 = 4
    ack_mode = 0;
    sum_v = '{16'd10, 16'hFFFD, 16'd5, 16'd7, 16'd1, 16'd1, 16'd1, 16'd1};
    zero_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_layer(2'd3, 3, 1, {$urandom, $urandom}, 3, 0, -1);

    // Tail mask on the third partial of each output
    run_layer(2'd1, 2, 2, 64'h00FF, 0, 0, -1);

    // Backpressure: hold the result for 5 cycles, then release
    ack_mode = 2;
    fork
      run_layer(2'd2, 1, 2, 64'h0F0F, 0, 0, -1);
      begin : bp
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus.o_acc_rdy) begin got = 1; break; end
        end
        check("bp_result_pending", 64'(got), 64'd1);
        repeat (5) @(negedge clk);
        check("bp_hold_sum_ack", 64'(bus.o_sum_ack), 64'd0);
        ack_mode = 0;
        @(negedge clk);
        check("bp_release_sum_ack", 64'(bus.o_sum_ack), 64'd1);
      end
    join

    // Saturation over 4096 partials
    run_layer(2'd3, 4095, 0, 64'hA5A5, 1, 0, -1);
    run_layer(2'd3, 4095, 0, 64'h5A5A, 2, 0, -1);

    // Zero flag
    sum_v = '{16'h1234}; zero_v = '{1};
    run_layer(2'd0, 0, 0, 64'h3, 3, 0, -1);
    run_layer(2'd0, 0, 3, 64'h7, 0, 1, -1);

    // Randomized layers with random gaps and random result backpressure
    ack_mode = 1;
    for (int l = 0; l < 8; l++)
      run_layer(2'($urandom_range(0, 3)), $urandom_range(0, 5), $urandom_range(0, 4),
                {$urandom, $urandom}, 0, 1, -1);

    // Reset after 2 of 4 sums, then a clean layer: 1+2+3+4 = 10
    ack_mode = 0;
    run_layer(2'd2, 3, 0, 64'hFF, 0, 0, 2);
    sum_v = '{16'd1, 16'd2, 16'd3, 16'd4}; zero_v = '{0, 0, 0, 0};
    run_layer(2'd1, 3, 0, 64'hF0, 3, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
